lda_cmdq_peripheral: RTL

Next-generation Avalon-MM slave front end for the line drawing accelerator (LDA). It has parametrised coordinate and colour widths and a DEPTH-entry command FIFO of queued lines, so the CPU can post several lines without waiting. A dispatcher FSM feeds the LDA controller one line at a time over a go/done handshake. It adds sticky done and overflow status, an interrupt output and a completed-line counter. It sits between the Avalon interconnect and the LDA controller FSM.

---
 rtl/lda_cmdq_peripheral.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/lda_cmdq_peripheral.sv
// Avalon-MM command-queue front end for the line drawing accelerator.
// Lines are staged in registers, pushed into a FIFO by GO and dispatched one at a time.
module lda_cmdq_peripheral #(
  parameter int X_W   = 9,
  parameter int Y_W   = 10,
  parameter int C_W   = 3,
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           chipselect,
  input  logic [2:0]     address,
  input  logic           read,
  input  logic           write,
  input  logic [31:0]    writedata,
  output logic [31:0]    readdata,
  output logic           waitrequest,
  output logic           irq,
  output logic           go,
  output logic [X_W-1:0] x0,
  output logic [X_W-1:0] x1,
  output logic [Y_W-1:0] y0,
  output logic [Y_W-1:0] y1,
  output logic [C_W-1:0] color,
  input  logic           done
);

  localparam int PW      = $clog2(DEPTH);
  localparam int ENTRY_W = 2 * X_W + 2 * Y_W + C_W;
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];
  localparam logic [PW-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [1:0]       r_mode;
  logic [X_W-1:0]   r_startX;
  logic [Y_W-1:0]   r_startY;
  logic [X_W-1:0]   r_endX;
  logic [Y_W-1:0]   r_endY;
  logic [C_W-1:0]   r_color;
  logic             r_doneSticky;
  logic             r_ovfSticky;
  logic [31:0]      r_lineCount;
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [PW:0]      r_count;

  logic w_full;
  logic w_empty;
  logic w_wrEn;
  logic w_goWr;
  logic w_push;
  logic w_pop;
  logic w_lineDone;
  logic w_statusWr;
  logic w_unused;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);

  // A GO into a full queue stalls the bus in stall mode; poll mode drops it instead.
  assign waitrequest = chipselect & write & (address == 3'd2) & w_full & ~r_mode[0];
  assign w_wrEn      = chipselect & write & ~waitrequest;
  assign w_goWr      = w_wrEn & (address == 3'd2);
  assign w_push      = w_goWr & ~w_full;
  assign w_statusWr  = w_wrEn & (address == 3'd1);
  assign w_unused    = &{1'b0, writedata, 1'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_pop       = 1'b0;
    w_lineDone  = 1'b0;
    go          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_stateNext = S_ISSUE;
        end
      end
      S_ISSUE: begin
        go          = 1'b1;
        w_stateNext = S_WAIT;
      end
      S_WAIT: begin
        if (done) begin
          w_lineDone  = 1'b1;
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= {r_startX, r_startY, r_endX, r_endY, r_color};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_count      <= '0;
      r_mode       <= '0;
      r_startX     <= '0;
      r_startY     <= '0;
      r_endX       <= '0;
      r_endY       <= '0;
      r_color      <= '0;
      r_doneSticky <= 1'b0;
      r_ovfSticky  <= 1'b0;
      r_lineCount  <= '0;
      irq          <= 1'b0;
      x0           <= '0;
      y0           <= '0;
      x1           <= '0;
      y1           <= '0;
      color        <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;

      if (w_pop) {x0, y0, x1, y1, color} <= r_mem[r_rdPtr];

      if (w_wrEn && address == 3'd0) r_mode <= writedata[1:0];
      if (w_wrEn && address == 3'd3) begin
        r_startX <= writedata[X_W-1:0];
        r_startY <= writedata[16 +: Y_W];
      end
      if (w_wrEn && address == 3'd4) begin
        r_endX <= writedata[X_W-1:0];
        r_endY <= writedata[16 +: Y_W];
      end
      if (w_wrEn && address == 3'd5) r_color <= writedata[C_W-1:0];

      // Sticky bits: a set on the same edge as a W1C clear takes priority.
      if (w_lineDone && w_empty && !w_push)  r_doneSticky <= 1'b1;
      else if (w_statusWr && writedata[0])   r_doneSticky <= 1'b0;
      if (w_goWr && w_full && r_mode[0])     r_ovfSticky <= 1'b1;
      else if (w_statusWr && writedata[3])   r_ovfSticky <= 1'b0;

      if (w_wrEn && address == 3'd6) r_lineCount <= '0;
      else if (w_lineDone)           r_lineCount <= r_lineCount + 32'd1;

      irq <= r_mode[1] & (r_doneSticky | r_ovfSticky);
    end
  end

  always_comb begin
    readdata = '0;
    if (chipselect && read) begin
      case (address)
        3'd0: readdata[1:0] = r_mode;
        3'd1: begin
          readdata[0]         = r_doneSticky;
          readdata[1]         = (r_state != S_IDLE) || !w_empty;
          readdata[2]         = w_full;
          readdata[3]         = r_ovfSticky;
          readdata[8 +: PW+1] = r_count;
        end
        3'd3: begin
          readdata[X_W-1:0]   = r_startX;
          readdata[16 +: Y_W] = r_startY;
        end
        3'd4: begin
          readdata[X_W-1:0]   = r_endX;
          readdata[16 +: Y_W] = r_endY;
        end
        3'd5: readdata[C_W-1:0] = r_color;
        3'd6: readdata = r_lineCount;
        default: readdata = '0;
      endcase
    end
  end

endmodule
